muldiv_seq_ctrl: RTL and testbench

//   Sequencer that time-shares one external 32-bit ripple add/sub unit to run iterative MULTU and DIVU.

---
 rtl/muldiv_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_muldiv_seq_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq_ctrl.sv
// Iterative MULTU/DIVU sequencer driving one shared external add/sub unit.
// One adder pass per cycle; hi/lo hold the HI/LO result pair.
module muldiv_seq_ctrl #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] adder_a,
   output logic [WIDTH-1:0] adder_b,
   output logic             adder_cin,
   input  logic [WIDTH-1:0] adder_sum,
   input  logic             adder_cout
);

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, m_q, m_d;
   logic               dbz_q, dbz_d;
   logic               top;
   logic [WIDTH-1:0]   shifted;

   assign top     = hi_q[WIDTH-1];
   assign shifted = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         m_q     <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         m_q     <= m_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      m_d       = m_q;
      dbz_d     = dbz_q;
      adder_a   = '0;
      adder_b   = '0;
      adder_cin = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               m_d   = src_b;
               dbz_d = 1'b0;
               if (!op) begin
                  lo_d    = src_b;
                  hi_d    = '0;
                  m_d     = src_a;
                  state_d = StMul;
               end else if (src_b != '0) begin
                  lo_d    = src_a;
                  hi_d    = '0;
                  state_d = StDiv;
               end else begin
                  hi_d    = src_a;
                  lo_d    = '1;
                  dbz_d   = 1'b1;
                  state_d = StDone;
               end
            end
         end
         StMul: begin
            adder_a = hi_q;
            adder_b = lo_q[0] ? m_q : '0;
            hi_d    = {adder_cout, adder_sum[WIDTH-1:1]};
            lo_d    = {adder_sum[0], lo_q[WIDTH-1:1]};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StDone;
         end
         StDiv: begin
            adder_a   = shifted;
            adder_b   = m_q;
            adder_cin = 1'b1;
            // top set: shifted remainder exceeds M, wrapped difference is exact
            if (top || !adder_cout) begin
               hi_d = adder_sum;
               lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
               hi_d = shifted;
               lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy        = (state_q == StMul) || (state_q == StDiv);
   assign done        = (state_q == StDone);
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Bench for muldiv_seq_ctrl: models the external adder, runs directed vectors,
// corner sequences and random ops against a 64-bit arithmetic reference.
module tb_muldiv_seq_ctrl;

   localparam int unsigned WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic             op;
   logic [WIDTH-1:0] src_a, src_b;
   logic             busy, done, div_by_zero;
   logic [WIDTH-1:0] hi, lo;
   logic [WIDTH-1:0] adder_a, adder_b, adder_sum;
   logic             adder_cin, adder_cout;

   int checks = 0;
   int errors = 0;
   bit cout_seen;

   always #5 clk = ~clk;

   muldiv_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .op         (op),
      .src_a      (src_a),
      .src_b      (src_b),
      .busy       (busy),
      .done       (done),
      .div_by_zero(div_by_zero),
      .hi         (hi),
      .lo         (lo),
      .adder_a    (adder_a),
      .adder_b    (adder_b),
      .adder_cin  (adder_cin),
      .adder_sum  (adder_sum),
      .adder_cout (adder_cout)
   );

   // External ripple add/sub unit; on subtract cout flags a borrow
   always_comb begin
      if (!adder_cin) begin
         {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b};
      end else begin
         adder_sum  = adder_a - adder_b;
         adder_cout = (adder_a < adder_b);
      end
   end

   typedef struct {
      string       name;
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      logic        exp_dbz;
      int          glitch_at;
      bit          need_cout;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // glitch_at: cycle after accept at which a stray start is pulsed (0 = none,
   // -1 = during the DONE cycle)
   task automatic run_op(input string name, input logic o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input logic exp_dbz,
                         input int glitch_at);
      int lat;
      int busy_cnt;
      int exp_lat;
      exp_lat   = exp_dbz ? 1 : 33;
      busy_cnt  = 0;
      cout_seen = 1'b0;
      @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(posedge clk); #1;
      start = 1'b0; src_a = $urandom; src_b = $urandom; op = $urandom_range(0, 1);
      lat = 1;
      while (!done && lat < 40) begin
         if (busy) busy_cnt++;
         if (busy && adder_cout) cout_seen = 1'b1;
         start = (lat == glitch_at);
         @(posedge clk); #1;
         start = 1'b0;
         lat++;
      end
      check({name, " done_seen"}, 64'(done), 64'd1);
      check({name, " latency"}, 64'(lat), 64'(exp_lat));
      check({name, " busy_cycles"}, 64'(busy_cnt), 64'(exp_dbz ? 0 : 32));
      check({name, " hi"}, 64'(hi), 64'(exp_hi));
      check({name, " lo"}, 64'(lo), 64'(exp_lo));
      check({name, " dbz"}, 64'(div_by_zero), 64'(exp_dbz));
      check({name, " adder_idle"}, {31'd0, adder_cin, adder_a}, 64'd0);
      if (glitch_at < 0) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({name, " done_pulse"}, {62'd0, done, busy}, 64'd0);
      check({name, " hold"}, {hi, lo}, {exp_hi, exp_lo});
   endtask

   function automatic logic [64:0] model(input logic o, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] p;
      if (!o) begin
         p = 64'(a) * 64'(b);
         return {1'b0, p};
      end else if (b == 0) begin
         return {1'b1, a, 32'hFFFF_FFFF};
      end else begin
         return {1'b0, a % b, a / b};
      end
   endfunction

   initial begin
      vec_t vecs[$];
      logic [64:0] ref_res;
      logic        ro;
      logic [31:0] ra, rb;
      bit          saw_done;

      rst_n = 1'b0; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy_done_dbz", {61'd0, busy, done, div_by_zero}, 64'd0);
      check("reset hi_lo", {hi, lo}, 64'd0);
      check("reset adder", {31'd0, adder_cin, adder_b}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      vecs.push_back('{"mul3x5", 1'b0, 32'd3, 32'd5, 32'd0, 32'hF, 1'b0, 0, 1'b0});
      vecs.push_back('{"mulmax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                       32'h1, 1'b0, 0, 1'b1});
      vecs.push_back('{"div100_7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0, 1'b0});
      vecs.push_back('{"divmax_1", 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF,
                       1'b0, 0, 1'b0});
      vecs.push_back('{"divtop", 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE,
                       32'd1, 1'b0, 0, 1'b0});
      vecs.push_back('{"div5_0", 1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 0, 1'b0});
      vecs.push_back('{"mul2x2_clr", 1'b0, 32'd2, 32'd2, 32'd0, 32'd4, 1'b0, 0, 1'b0});
      vecs.push_back('{"mul_glitch", 1'b0, 32'd3, 32'd5, 32'd0, 32'hF, 1'b0, 5, 1'b0});
      vecs.push_back('{"div_glitch", 1'b1, 32'd1000, 32'd33, 32'd10, 32'd30, 1'b0, 5, 1'b0});
      vecs.push_back('{"done_start", 1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, -1, 1'b0});

      foreach (vecs[i]) begin
         run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi,
                vecs[i].exp_lo, vecs[i].exp_dbz, vecs[i].glitch_at);
         if (vecs[i].need_cout) check({vecs[i].name, " cout_seen"}, 64'(cout_seen), 64'd1);
      end

      // Reset during cycle 10 of a multiply
      @(negedge clk);
      start = 1'b1; op = 1'b0; src_a = 32'd7; src_b = 32'd9;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("pre_reset busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("abort busy_done", {62'd0, busy, done}, 64'd0);
      check("abort hi_lo", {hi, lo}, 64'd0);
      saw_done = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      check("abort no_done", 64'(saw_done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("after_reset", 1'b0, 32'd7, 32'd9, 32'd0, 32'd63, 1'b0, 0);

      for (int i = 0; i < 40; i++) begin
         ro = 1'($urandom_range(0, 1));
         ra = $urandom;
         case (i % 4)
            0: rb = $urandom;
            1: rb = $urandom_range(0, 15);
            2: rb = 32'h8000_0000 | $urandom;
            default: rb = (i % 8 == 3) ? 32'd0 : $urandom_range(1, 32'hFFFF);
         endcase
         ref_res = model(ro, ra, rb);
         run_op($sformatf("rnd%0d", i), ro, ra, rb, ref_res[63:32], ref_res[31:0],
                ref_res[64], 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
